tone_detector: RTL

Receive-side counterpart of the square-wave tone generator. Samples an external or looped-back audio square wave, measures its period in clk cycles, and confirms a stable tone after CONFIRM consistent periods. Reports the measured period, a valid flag, and a match against the nominal TONE_FREQ. Used by the audio loopback self-test and by the note-recognition path.

---
 rtl/tone_detector_pkg.sv | 38 +++
 rtl/tone_detector_if.sv | 30 +++
 rtl/tone_detector_sync_edge_detect.sv | 31 +++
 rtl/tone_detector.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/tone_detector_pkg.sv
// Shared definitions for the audio tone path.
//   - Default clock and frequency parameters for tone_detector.
//   - State encoding for the period-measurement FSM.
//   - period_of(): converts a frequency in Hz to a period in clk cycles.
//   - within_tol(): tolerance test |val - ref_val| <= ref_val >> shift.
package tone_detector_pkg;

  localparam int unsigned DEF_CLK_FREQ  = 100_000_000;
  localparam int unsigned DEF_TONE_FREQ = 1000;
  localparam int unsigned DEF_MIN_FREQ  = 50;
  localparam int unsigned DEF_MAX_FREQ  = 20_000;
  localparam int unsigned DEF_TOL_SHIFT = 4;
  localparam int unsigned DEF_CONFIRM   = 3;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LOCKED
  } state_t;

  function automatic logic [31:0] period_of(input int unsigned clk_freq,
                                            input int unsigned freq);
    return 32'(clk_freq / freq);
  endfunction

  // The difference is taken at 33 bits signed so neither operand order can
  // wrap around and fake a match.
  function automatic logic within_tol(input logic [31:0] val,
                                      input logic [31:0] ref_val,
                                      input int unsigned shift);
    logic signed [32:0] diff;
    logic [32:0]        mag;
    diff = $signed({1'b0, val}) - $signed({1'b0, ref_val});
    mag  = diff[32] ? $unsigned(-diff) : $unsigned(diff);
    return mag <= {1'b0, ref_val >> shift};
  endfunction

endpackage

// File: rtl/tone_detector_if.sv
// Signal bundle between the tone detector and its consumer.
//   audio_in   : raw asynchronous square wave into the detector
//   tone_valid : locked to a stable tone
//   period_out : last accepted period in clk cycles
//   period_stb : one-cycle pulse when period_out updates
//   freq_match : locked and period_out within tolerance of the nominal tone
// master = detector side, slave = consumer side (which also sources audio_in).
interface tone_detector_if;
  logic        audio_in;
  logic        tone_valid;
  logic [31:0] period_out;
  logic        period_stb;
  logic        freq_match;

  modport master (
    input  audio_in,
    output tone_valid,
    output period_out,
    output period_stb,
    output freq_match
  );

  modport slave (
    output audio_in,
    input  tone_valid,
    input  period_out,
    input  period_stb,
    input  freq_match
  );
endinterface

// File: rtl/tone_detector_sync_edge_detect.sv
// Two-flop synchronizer followed by a rising-edge detector, reusable for any
// asynchronous level input (audio, buttons).
//   clk      : system clock
//   rst      : synchronous reset, active-high
//   async_in : asynchronous input level
//   rise     : one-cycle pulse on a synchronized 0->1 transition
// Pin-to-rise latency is two clocks; the consumer registers it on the third.
module tone_detector_sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/tone_detector.sv
// Measures the period of a square-wave tone and locks after CONFIRM
// consecutive consistent periods.
//   clk : system clock
//   rst : synchronous reset, active-high
//   bus : tone_detector_if.master (audio_in in; tone_valid, period_out,
//         period_stb, freq_match out, all registered)
// cnt restarts at 1 on every accepted rise, so its value at the next accepted
// rise is the period in clk cycles. Rises closer than MIN_PERIOD are glitches;
// no accepted rise for TIMEOUT cycles means silence and returns to IDLE.
module tone_detector
  import tone_detector_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
  parameter int unsigned TONE_FREQ = DEF_TONE_FREQ,
  parameter int unsigned MIN_FREQ  = DEF_MIN_FREQ,
  parameter int unsigned MAX_FREQ  = DEF_MAX_FREQ,
  parameter int unsigned TOL_SHIFT = DEF_TOL_SHIFT,
  parameter int unsigned CONFIRM   = DEF_CONFIRM
) (
  input logic             clk,
  input logic             rst,
  tone_detector_if.master bus
);

  localparam logic [31:0] NOM_PERIOD = period_of(CLK_FREQ, TONE_FREQ);
  localparam logic [31:0] MIN_PERIOD = period_of(CLK_FREQ, MAX_FREQ);
  localparam logic [31:0] TIMEOUT    = period_of(CLK_FREQ, MIN_FREQ);
  localparam int          MCW        = $clog2(CONFIRM + 1);
  localparam logic [MCW-1:0] CONFIRM_C = MCW'(CONFIRM);

  logic           rise;
  state_t         state_q, state_d;
  logic [31:0]    cnt_q, cnt_d;
  logic [31:0]    ref_q, ref_d;
  logic [31:0]    period_q, period_d;
  logic [MCW-1:0] mcnt_q, mcnt_d, mcnt_inc;
  logic           valid_q, valid_d;
  logic           stb_q, stb_d;
  logic           fmatch_q;
  logic           match, accept, timeout;

  tone_detector_sync_edge_detect u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (bus.audio_in),
    .rise     (rise)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ref_q    <= '0;
      period_q <= '0;
      mcnt_q   <= '0;
      valid_q  <= 1'b0;
      stb_q    <= 1'b0;
      fmatch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ref_q    <= ref_d;
      period_q <= period_d;
      mcnt_q   <= mcnt_d;
      valid_q  <= valid_d;
      stb_q    <= stb_d;
      // Judged from the registered outputs, so it trails them by one cycle.
      fmatch_q <= valid_q && within_tol(period_q, NOM_PERIOD, TOL_SHIFT);
    end
  end

  // NOTE: every variable gets a default before the case so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ref_d    = ref_q;
    period_d = period_q;
    mcnt_d   = mcnt_q;
    valid_d  = valid_q;
    stb_d    = 1'b0;
    match    = within_tol(cnt_q, ref_q, TOL_SHIFT);
    accept   = rise && (cnt_q >= MIN_PERIOD);
    timeout  = (cnt_q == TIMEOUT);
    mcnt_inc = mcnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = 32'd1;
          mcnt_d  = '0;
        end
      end

      MEASURE, LOCKED: begin
        if (!timeout) cnt_d = cnt_q + 32'd1;

        // Silence wins over a rise landing in the same cycle.
        if (timeout) begin
          state_d  = IDLE;
          cnt_d    = '0;
          valid_d  = 1'b0;
          period_d = '0;
          mcnt_d   = '0;
        end else if (accept) begin
          cnt_d = 32'd1;
          ref_d = cnt_q;
          if (state_q == MEASURE) begin
            // The first period after IDLE has no reference to compare with.
            if (mcnt_q == '0 || !match) begin
              mcnt_d = MCW'(1);
            end else begin
              mcnt_d = mcnt_inc;
              if (mcnt_inc == CONFIRM_C) begin
                state_d  = LOCKED;
                valid_d  = 1'b1;
                period_d = cnt_q;
                stb_d    = 1'b1;
              end
            end
          end else if (match) begin
            period_d = cnt_q;
            stb_d    = 1'b1;
          end else begin
            // The off-tone period becomes the new reference and counts as
            // the first of the next confirmation run.
            state_d = MEASURE;
            valid_d = 1'b0;
            mcnt_d  = MCW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.tone_valid = valid_q;
  assign bus.period_out = period_q;
  assign bus.period_stb = stb_q;
  assign bus.freq_match = fmatch_q;

endmodule
